// File: rtl/odo_pkg.sv
// odo_pkg: shared widths and FSM state type for the Odo S-box lane feeder
package odo_pkg;
  localparam int ODO_SMALL_W = 6;
  localparam int ODO_FEED_LANES = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} feed_state_t;
endpackage

// File: rtl/odo_tag_delay.sv
// odo_tag_delay: DEPTH-stage shift register carrying the S-box issue-valid tag
module odo_tag_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tag_in,
  output logic tag_out
);
  logic [DEPTH-1:0] line;
  always_ff @(posedge clk or posedge rst)
    if (rst) line <= '0;
    else line <= DEPTH'({line, tag_in});
  assign tag_out = line[DEPTH-1];
endmodule

// File: rtl/odo_sbox_lane_feeder.sv
// odo_sbox_lane_feeder: serialises a wide word through one external S-box, one lane per cycle
// Optional word_cnt output when ODO_SBOX_FEED_CNT_EN is defined.
module odo_sbox_lane_feeder
  import odo_pkg::*;
#(
  parameter int LANES = ODO_FEED_LANES,
  parameter int LANE_W = ODO_SMALL_W,
  parameter int SBOX_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic [LANE_W-1:0]       sbox_in,
  input  logic [LANE_W-1:0]       sbox_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data
`ifdef ODO_SBOX_FEED_CNT_EN
  ,
  output logic [31:0]             word_cnt
`endif
);
  localparam int CW = $clog2(LANES + 1);
  feed_state_t state;
  logic [CW-1:0] issue_cnt, cap_cnt;
  logic [LANES*LANE_W-1:0] lanes, result, next_res;
  logic issued, tag;
  assign in_ready = state == IDLE && !reset;
  // issued marks a valid sbox_in; the tag line adds the ROM read latency
  odo_tag_delay #(.DEPTH(SBOX_LAT)) u_tag (
    .clk(clk),
    .rst(reset),
    .tag_in(issued),
    .tag_out(tag)
  );
  always_comb begin
    next_res = result;
    next_res[cap_cnt*LANE_W +: LANE_W] = sbox_out;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      issue_cnt <= '0;
      cap_cnt <= '0;
      sbox_in <= '0;
      issued <= 1'b0;
      lanes <= '0;
      result <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      issued <= 1'b0;
      case (state)
        // lane 0 goes out on the accept edge so the ROM read overlaps the FSM step
        IDLE: if (in_valid) begin
          lanes <= in_data;
          sbox_in <= in_data[LANE_W-1:0];
          issued <= 1'b1;
          issue_cnt <= CW'(1);
          state <= ISSUE;
        end
        ISSUE: if (issue_cnt == CW'(LANES)) begin
          sbox_in <= '0;
          state <= DRAIN;
        end else begin
          sbox_in <= lanes[issue_cnt*LANE_W +: LANE_W];
          issued <= 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        DRAIN: ;
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          issue_cnt <= '0;
          cap_cnt <= '0;
          state <= IDLE;
        end
      endcase
      if (tag && (state == ISSUE || state == DRAIN)) begin
        result <= next_res;
        cap_cnt <= cap_cnt + 1'b1;
        if (cap_cnt == CW'(LANES - 1)) begin
          out_data <= next_res;
          out_valid <= 1'b1;
          state <= HOLD;
        end
      end
    end
`ifdef ODO_SBOX_FEED_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) word_cnt <= '0;
    else if (out_valid && out_ready) word_cnt <= word_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_odo_sbox_lane_feeder.sv
// tb_odo_sbox_lane_feeder: directed checks of the lane feeder around a registered S-box model
module tb_odo_sbox_lane_feeder;
  localparam int W = 60;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic [5:0] sbox_in;
  logic [5:0] sbox_out = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_data;
  int tests = 0;
  int fails = 0;
`ifdef ODO_SBOX_FEED_CNT_EN
  logic [31:0] word_cnt;
`endif

  odo_sbox_lane_feeder dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .sbox_in(sbox_in),
    .sbox_out(sbox_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef ODO_SBOX_FEED_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  // registered small S-box; only the listed points are exercised by the vectors
  function automatic logic [5:0] sbox_f(input logic [5:0] x);
    case (x)
      6'd0:  return 6'h1c;
      6'd1:  return 6'h07;
      6'd63: return 6'h2f;
      6'd43: return 6'h00;
      default: return x ^ 6'h15;
    endcase
  endfunction
  always @(posedge clk) sbox_out <= sbox_f(sbox_in);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 40 && !in_ready; i++) step();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: in_ready=%b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_out: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sbox_in !== 6'h00 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sbox_in=%h out_data=%h, required 0 0 00 0",
               in_ready, out_valid, sbox_in, out_data);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_zero();
    int lat;
    out_ready = 1'b1;
    send('0);
    wait_out(lat);
    tests++;
    if (lat != 11) begin
      fails++;
      $display("FAIL zero_latency: %0d edges, required 11", lat);
    end
    tests++;
    if (out_data !== {10{6'h1c}}) begin
      fails++;
      $display("FAIL zero_data: out_data=%h, required %h", out_data, {10{6'h1c}});
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL zero_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_lanes();
    int lat;
    logic [5:0] exp_in [3];
    exp_in[0] = 6'd1;
    exp_in[1] = 6'd63;
    exp_in[2] = 6'd43;
    send({42'd0, 6'd43, 6'd63, 6'd1});
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (sbox_in !== exp_in[i]) begin
        fails++;
        $display("FAIL lanes_issue%0d: sbox_in=%h, required %h", i, sbox_in, exp_in[i]);
      end
      step();
    end
    wait_out(lat);
    tests++;
    if (out_data !== {{7{6'h1c}}, 6'h00, 6'h2f, 6'h07}) begin
      fails++;
      $display("FAIL lanes_data: out_data=%h, required %h", out_data, {{7{6'h1c}}, 6'h00, 6'h2f, 6'h07});
    end
    step();
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    send('0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_data !== {10{6'h1c}} || in_ready !== 1'b0 || sbox_in !== 6'h00) begin
        fails++;
        $display("FAIL hold_cycle%0d: out_valid=%b out_data=%h in_ready=%b sbox_in=%h, required 1 %h 0 00",
                 i, out_valid, out_data, in_ready, sbox_in, {10{6'h1c}});
      end
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stale;
    out_ready = 1'b1;
    send({10{6'd1}});
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || sbox_in !== 6'h00 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: out_valid=%b sbox_in=%h in_ready=%b, required 0 00 0",
               out_valid, sbox_in, in_ready);
    end
    step();
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid === 1'b1) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++;
      $display("FAIL midreset_stale: out_valid high %0d cycles, required 0", stale);
    end
    send('0);
    wait_out(lat);
    tests++;
    if (lat != 11 || out_data !== {10{6'h1c}}) begin
      fails++;
      $display("FAIL midreset_word: latency=%0d out_data=%h, required 11 %h", lat, out_data, {10{6'h1c}});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    logic [W-1:0] exp_w [3];
    int acc_t [3];
    int na, nout, cyc;
    logic acc, hs;
    words[0] = {10{6'd1}};
    words[1] = {10{6'd63}};
    words[2] = {10{6'd43}};
    exp_w[0] = {10{6'h07}};
    exp_w[1] = {10{6'h2f}};
    exp_w[2] = {10{6'h00}};
    na = 0;
    nout = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = words[0];
    while (nout < 3 && cyc < 200) begin
      acc = in_valid && in_ready;
      hs = out_valid && out_ready;
      if (hs) begin
        tests++;
        if (out_data !== exp_w[nout]) begin
          fails++;
          $display("FAIL b2b_data%0d: out_data=%h, required %h", nout, out_data, exp_w[nout]);
        end
        nout++;
      end
      step();
      cyc++;
      if (acc) begin
        acc_t[na] = cyc;
        na++;
        in_valid = na < 3;
        in_data = na < 3 ? words[na] : '0;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (na != 3 || nout != 3) begin
      fails++;
      $display("FAIL b2b_count: accepts=%0d outputs=%0d, required 3 3", na, nout);
    end else begin
      // accept, 11 edges to out_valid, handshake edge, then one idle edge before the next accept
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (acc_t[i] - acc_t[i-1] != 13) begin
          fails++;
          $display("FAIL b2b_spacing%0d: %0d cycles, required 13", i, acc_t[i] - acc_t[i-1]);
        end
      end
    end
  endtask

`ifdef ODO_SBOX_FEED_CNT_EN
  task automatic test_word_cnt();
    int lat;
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send('0);
      wait_out(lat);
      step();
    end
    tests++;
    if (word_cnt !== 32'd3) begin
      fails++;
      $display("FAIL word_cnt_three: word_cnt=%0d, required 3", word_cnt);
    end
    force dut.word_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.word_cnt;
    send('0);
    wait_out(lat);
    step();
    tests++;
    if (word_cnt !== 32'd0) begin
      fails++;
      $display("FAIL word_cnt_wrap: word_cnt=%h, required 0", word_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_lanes();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef ODO_SBOX_FEED_CNT_EN
    test_word_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
